// File: rtl/soc_delay_scheduler.sv
// Shared one-shot delay engine: grants requesters round-robin, counts the granted
// delay down on a single counter and pulses done for the owner when it expires.
module soc_delay_scheduler #(
    parameter int unsigned REQ_COUNT = 4,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                res_n,
    input  logic [REQ_COUNT-1:0]                req,
    input  logic [REQ_COUNT-1:0][CNT_WIDTH-1:0] req_delay,
    input  logic [REQ_COUNT-1:0]                cancel,
    output logic [REQ_COUNT-1:0]                ack,
    output logic [REQ_COUNT-1:0]                done,
    output logic                                busy,
    output logic [3:0]                          active_id,
    output logic [CNT_WIDTH-1:0]                remaining
);

    localparam int unsigned IdW = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       ptr_q, ptr_d;
    logic [IdW-1:0]       aid_q, aid_d;
    logic [REQ_COUNT-1:0] ack_q, ack_d;
    logic [REQ_COUNT-1:0] done_q, done_d;
    logic                 busy_q, busy_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;

    logic [IdW-1:0]       win_idx;
    logic                 win_found;
    int unsigned          scan_idx;
    logic [IdW-1:0]       ptr_inc;

    // First pending requester at or above the pointer, wrapping modulo REQ_COUNT.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < REQ_COUNT; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= REQ_COUNT) begin
                scan_idx = scan_idx - REQ_COUNT;
            end
            if (!win_found && req[IdW'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = IdW'(scan_idx);
            end
        end
    end

    assign ptr_inc = (aid_q == IdW'(REQ_COUNT - 1)) ? '0 : aid_q + IdW'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        aid_d   = aid_q;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        rem_d   = rem_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d        = StCount;
                    ack_d[win_idx] = 1'b1;
                    aid_d          = win_idx;
                    busy_d         = 1'b1;
                    // A zero delay is serviced exactly like a delay of one.
                    rem_d          = (req_delay[win_idx] == '0) ? CNT_WIDTH'(1)
                                                                : req_delay[win_idx];
                end
            end
            StCount: begin
                if (cancel[aid_q]) begin
                    state_d = StIdle;
                    rem_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_inc;
                end else if (rem_q <= CNT_WIDTH'(1)) begin
                    state_d       = StDone;
                    rem_d         = '0;
                    done_d[aid_q] = 1'b1;
                end else begin
                    rem_d = rem_q - CNT_WIDTH'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                ptr_d   = ptr_inc;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            aid_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            aid_q   <= aid_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rem_q   <= rem_d;
        end
    end

    assign ack       = ack_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign active_id = 4'(aid_q);
    assign remaining = rem_q;

endmodule

// File: doc/soc_delay_scheduler.md
# soc_delay_scheduler

Shares one hardware down-counter among up to 16 requesters that each need a one-shot delay, e.g. peripheral drivers, DMA pacing or software-visible wait engines in the SoC. Requesters present a delay value with a level request. The block grants them round-robin, counts the granted delay, and returns a one-cycle completion pulse. It sits beside the SoC timer block, so the general-purpose timers stay free for software.

## Interface
- REQ_COUNT, 4, number of requesters; legal range 2..16.
- CNT_WIDTH, 32, width of delay values and of the counter.

- clk  input  1  system clock; all state updates on rising edge.
- res_n  input  1  reset, asynchronous and active-low; clears all state immediately.
- req  input  REQ_COUNT  per-requester level request; held high until ack.
- req_delay  input  [CNT_WIDTH-1:0] x REQ_COUNT  per-requester delay in clk cycles; must be stable while req is high.
- cancel  input  REQ_COUNT  per-requester abort; acts only on the active requester in COUNT.
- ack  output  REQ_COUNT  one-hot, one-cycle grant pulse; delay latched.
- done  output  REQ_COUNT  one-hot, one-cycle completion pulse.
- busy  output  1  high in COUNT and DONE.
- active_id  output  4  index of granted requester; holds last value when idle.
- remaining  output  CNT_WIDTH  current counter value.

## Operation
- FSM with three states: IDLE, COUNT, DONE. All outputs are registered.
- Reset value of every output is 0; the FSM resets to IDLE and the round-robin pointer resets to 0.
- IDLE:
  - If any req bit is high, pick the winner: the first set bit at or above the pointer, wrapping modulo REQ_COUNT.
  - Next cycle: state=COUNT, ack[winner]=1, active_id=winner, remaining=max(req_delay[winner],1).
  - If no req is high, stay in IDLE.
- COUNT:
  - If cancel[active_id]=1: go to IDLE, set remaining=0, no done pulse, pointer=active_id+1 (mod REQ_COUNT).
  - Else if remaining==1: go to DONE, remaining=0.
  - Else: remaining decrements by 1.
- DONE: done[active_id]=1 for this cycle only; pointer=active_id+1 (mod REQ_COUNT); next state IDLE.
- Ignored inputs:
  - req from any requester, including the active one, outside IDLE.
  - cancel bits for non-active requesters.
  - cancel in IDLE or DONE; completion in DONE is not revoked.
- Delay arithmetic:
  - Unsigned, CNT_WIDTH bits; the counter never wraps below 0.
  - Delay 0 behaves exactly as delay 1.
  - Delay 2^CNT_WIDTH-1 is legal.
- Requester protocol: drop req in the cycle after ack is seen. A req still high in the next IDLE is treated as a new request.

## Timing
- Grant latency: req high in IDLE at edge k gives ack high during cycle k+1 (counting from the edge).
- Delay D≥1, ack in cycle t:
  - remaining=D in cycle t, D-1 in t+1, ..., 1 in t+D-1.
  - done high in cycle t+D.
- Delay 0: done in cycle t+1.
- Back-to-back: done in cycle u, IDLE in u+1, next ack in u+2.
  - Minimum service period per request is D+2 cycles.
- Cancel sampled in COUNT cycle c: IDLE in c+1, and ack of the next request no earlier than c+2.
- res_n asserted mid-operation: outputs go to 0 immediately and no done is emitted. After release, the first edge with res_n high evaluates IDLE.
- Fairness: with all requesters pending continuously, each is granted once per REQ_COUNT grants.

## Test plan
- Reset: res_n low mid-COUNT → ack, done, busy, active_id, remaining all 0 asynchronously. After release, req[1] with delay 5 → ack[1] next cycle.
- Single request: req[2]=1, req_delay[2]=5 → ack[2] at cycle t; remaining 5,4,3,2,1; done[2] at t+5; busy low at t+6.
- Zero delay: req[0]=1, delay 0 → ack[0] at t, done[0] at t+1, remaining 1 then 0.
- Round-robin: req[0..3] all high, each delay 3 and re-asserted → grant order 0,1,2,3,0. Grants spaced 5 cycles apart.
- Cancel: req[1] delay 100, cancel[1] pulsed at remaining=40 → no done[1], state IDLE next cycle, pending req[2] acked one cycle later. cancel[3] pulsed at the same time has no effect.
- Wrap/extreme: REQ_COUNT=16, pointer=15, req[0] and req[15] high → 15 granted first, then 0. Delay 32'hFFFF_FFFF loads without overflow, checked over first 10 decrements.
